// File: rtl/data_memory_pipe.sv
// data_memory_pipe
// ----------------
// Parametrised single-port data memory for the load/store stage of the CPU
// datapath. It sits between the ALU address output and the write-back mux.
// Features: per-byte write enables, a pipelined read path of READ_LAT edges,
// a post-reset clear sequencer that zeroes every word before Ready is raised,
// and a one-cycle Error pulse for accesses at or beyond DEPTH.
//
// Ports:
//   Clock      - system clock, all state changes on the rising edge
//   Reset      - synchronous active-high reset
//   Adresa     - word address of the access
//   WriteData  - store data
//   ByteEn     - per-byte write enable, bit i covers WriteData[8i+7:8i]
//   MemWrite   - store request
//   MemRead    - load request
//   ReadData   - load data, holds its value between reads
//   ReadValid  - one-cycle pulse marking new ReadData
//   Ready      - memory accepts requests
//   Error      - one-cycle pulse for an accepted out-of-range access

module data_memory_pipe #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int DEPTH          = 256,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [ADDR_W-1:0]   Adresa,
    input  logic [DATA_W-1:0]   WriteData,
    input  logic [DATA_W/8-1:0] ByteEn,
    input  logic                MemWrite,
    input  logic                MemRead,
    output logic [DATA_W-1:0]   ReadData,
    output logic                ReadValid,
    output logic                Ready,
    output logic                Error
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so that DEPTH == 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  clearCnt_q;
    logic              ready_q;
    logic              error_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [READ_LAT-1:0] rdValid_q;
    logic [DATA_W-1:0]   rdData_q [READ_LAT];

    logic             inRange;
    logic [IDX_W-1:0] accIdx;
    logic             rdAccept;
    logic             wrAccept;
    logic             anyAccept;
    logic             clrWrite;

    // Request qualification. Requests only count when Ready was already high
    // before the edge and Reset is not being applied at that same edge.
    // The address is never wrapped: anything at or above DEPTH is out of range.
    always_comb begin
        inRange   = ({1'b0, Adresa} < DEPTH_EXT);
        accIdx    = Adresa[IDX_W-1:0];
        rdAccept  = !Reset && ready_q && MemRead;
        wrAccept  = !Reset && ready_q && MemWrite && inRange;
        anyAccept = !Reset && ready_q && (MemRead || MemWrite);
        clrWrite  = !Reset && (state_q == S_CLEAR);
    end

    // Control FSM: CLEAR walks the counter across every word, IDLE serves
    // requests. Ready is registered alongside the state so it is 0 on any
    // edge where Reset was sampled high.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            clearCnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    if (clearCnt_q == LAST_IDX) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        clearCnt_q <= clearCnt_q + 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Storage write port, kept free of reset so it maps onto block RAM.
    // The clear sequencer and user stores share this single port; they can
    // never collide because stores need Ready, which is low during CLEAR.
    always_ff @(posedge Clock) begin
        if (clrWrite) begin
            mem[clearCnt_q] <= '0;
        end else if (wrAccept) begin
            for (int b = 0; b < NB; b++) begin
                if (ByteEn[b]) begin
                    mem[accIdx][8*b +: 8] <= WriteData[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline. Stage 0 captures the word at the request edge, which
    // naturally gives read-before-write when a store hits the same address.
    // Later stages only move data forward alongside a valid bit so the
    // output register holds its value between reads.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int k = 0; k < READ_LAT; k++) begin
                rdValid_q[k] <= 1'b0;
                rdData_q[k]  <= '0;
            end
        end else begin
            rdValid_q[0] <= rdAccept;
            if (rdAccept) begin
                rdData_q[0] <= inRange ? mem[accIdx] : '0;
            end
            for (int k = 1; k < READ_LAT; k++) begin
                rdValid_q[k] <= rdValid_q[k-1];
                if (rdValid_q[k-1]) begin
                    rdData_q[k] <= rdData_q[k-1];
                end
            end
        end
    end

    // Error is tied to the request edge rather than the read latency, and a
    // combined read+write still produces only one pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= anyAccept && !inRange;
        end
    end

    assign ReadData  = rdData_q[READ_LAT-1];
    assign ReadValid = rdValid_q[READ_LAT-1];
    assign Ready     = ready_q;
    assign Error     = error_q;

endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe
// -------------------
// Directed bench for data_memory_pipe. Two instances share all inputs:
// dutA uses READ_LAT=1 and dutB uses READ_LAT=3, both with DEPTH=256 and the
// post-reset clear enabled, so every read exercises both latencies.

module tb_data_memory_pipe;

    logic        Clock;
    logic        Reset;
    logic [15:0] Adresa;
    logic [15:0] WriteData;
    logic [1:0]  ByteEn;
    logic        MemWrite;
    logic        MemRead;

    logic [15:0] ReadDataA, ReadDataB;
    logic        ReadValidA, ReadValidB;
    logic        ReadyA, ReadyB;
    logic        ErrorA, ErrorB;

    int checks = 0;
    int errors = 0;

    data_memory_pipe #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(256), .READ_LAT(1), .CLEAR_ON_RESET(1)
    ) dutA (
        .Clock(Clock), .Reset(Reset), .Adresa(Adresa), .WriteData(WriteData),
        .ByteEn(ByteEn), .MemWrite(MemWrite), .MemRead(MemRead),
        .ReadData(ReadDataA), .ReadValid(ReadValidA), .Ready(ReadyA), .Error(ErrorA)
    );

    data_memory_pipe #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(256), .READ_LAT(3), .CLEAR_ON_RESET(1)
    ) dutB (
        .Clock(Clock), .Reset(Reset), .Adresa(Adresa), .WriteData(WriteData),
        .ByteEn(ByteEn), .MemWrite(MemWrite), .MemRead(MemRead),
        .ReadData(ReadDataB), .ReadValid(ReadValidB), .Ready(ReadyB), .Error(ErrorB)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one rising edge and settle 1 time unit past it, so inputs change
    // and outputs are sampled away from the active edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        ByteEn    = 2'b00;
        WriteData = 16'h0000;
        Adresa    = 16'h0000;
    endtask

    task automatic writeWord(input logic [15:0] addr, input logic [15:0] data,
                             input logic [1:0] be);
        Adresa    = addr;
        WriteData = data;
        ByteEn    = be;
        MemWrite  = 1'b1;
        tick();
        idleInputs();
    endtask

    // Single read: dutA answers right after the request edge, dutB two edges
    // later; the intermediate samples confirm dutB stays quiet until then.
    task automatic readCheck(input string tag, input logic [15:0] addr,
                             input logic [15:0] expData);
        Adresa  = addr;
        MemRead = 1'b1;
        tick();
        idleInputs();
        checkOutput({tag, " A valid"}, 32'(ReadValidA), 32'd1);
        checkOutput({tag, " A data"},  32'(ReadDataA),  32'(expData));
        checkOutput({tag, " B early"}, 32'(ReadValidB), 32'd0);
        tick();
        checkOutput({tag, " A pulse end"}, 32'(ReadValidA), 32'd0);
        checkOutput({tag, " B early2"},    32'(ReadValidB), 32'd0);
        tick();
        checkOutput({tag, " B valid"}, 32'(ReadValidB), 32'd1);
        checkOutput({tag, " B data"},  32'(ReadDataB),  32'(expData));
        tick();
        checkOutput({tag, " B pulse end"}, 32'(ReadValidB), 32'd0);
    endtask

    task automatic waitReady(input string tag, input int expEdges);
        int cnt = 0;
        while (!ReadyA && cnt < 400) begin
            tick();
            cnt++;
        end
        checkOutput({tag, " edges to Ready"}, 32'(cnt), 32'(expEdges));
        checkOutput({tag, " B Ready"}, 32'(ReadyB), 32'd1);
    endtask

    task automatic applyStimulus();
        int cnt;
        logic sawBad;

        // Reset for two edges, then the clear sequence.
        idleInputs();
        Reset = 1'b1;
        tick();
        tick();
        checkOutput("reset Ready A",     32'(ReadyA),     32'd0);
        checkOutput("reset Ready B",     32'(ReadyB),     32'd0);
        checkOutput("reset ReadValid A", 32'(ReadValidA), 32'd0);
        checkOutput("reset ReadData B",  32'(ReadDataB),  32'd0);
        checkOutput("reset Error A",     32'(ErrorA),     32'd0);
        Reset = 1'b0;
        waitReady("clear", 256);
        readCheck("clear addr13", 16'd13, 16'h0000);

        // Basic store/load.
        writeWord(16'd13, 16'h00FF, 2'b11);
        readCheck("store13", 16'd13, 16'h00FF);

        // Byte enables.
        writeWord(16'd5, 16'h1234, 2'b11);
        writeWord(16'd5, 16'hABCD, 2'b10);
        readCheck("be upper", 16'd5, 16'hAB34);
        writeWord(16'd5, 16'hFFFF, 2'b00);
        checkOutput("be none Error", 32'(ErrorA), 32'd0);
        readCheck("be none", 16'd5, 16'hAB34);
        writeWord(16'd5, 16'h5678, 2'b01);
        readCheck("be lower", 16'd5, 16'hAB78);

        // Back-to-back pipelined reads.
        writeWord(16'd1, 16'h0011, 2'b11);
        writeWord(16'd2, 16'h0022, 2'b11);
        writeWord(16'd3, 16'h0033, 2'b11);
        MemRead = 1'b1;
        Adresa  = 16'd1;
        tick();
        checkOutput("pipe A1", 32'(ReadDataA), 32'h0011);
        checkOutput("pipe B quiet1", 32'(ReadValidB), 32'd0);
        Adresa = 16'd2;
        tick();
        checkOutput("pipe A2", 32'(ReadDataA), 32'h0022);
        checkOutput("pipe A2 valid", 32'(ReadValidA), 32'd1);
        checkOutput("pipe B quiet2", 32'(ReadValidB), 32'd0);
        Adresa = 16'd3;
        tick();
        checkOutput("pipe A3", 32'(ReadDataA), 32'h0033);
        checkOutput("pipe B1 valid", 32'(ReadValidB), 32'd1);
        checkOutput("pipe B1", 32'(ReadDataB), 32'h0011);
        idleInputs();
        tick();
        checkOutput("pipe A done", 32'(ReadValidA), 32'd0);
        checkOutput("pipe A hold", 32'(ReadDataA), 32'h0033);
        checkOutput("pipe B2 valid", 32'(ReadValidB), 32'd1);
        checkOutput("pipe B2", 32'(ReadDataB), 32'h0022);
        tick();
        checkOutput("pipe B3 valid", 32'(ReadValidB), 32'd1);
        checkOutput("pipe B3", 32'(ReadDataB), 32'h0033);
        tick();
        checkOutput("pipe B done", 32'(ReadValidB), 32'd0);
        checkOutput("pipe B hold", 32'(ReadDataB), 32'h0033);

        // Same-address read and write: old data first.
        writeWord(16'd7, 16'h0001, 2'b11);
        Adresa    = 16'd7;
        WriteData = 16'h0002;
        ByteEn    = 2'b11;
        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        tick();
        idleInputs();
        checkOutput("rbw A", 32'(ReadDataA), 32'h0001);
        tick();
        tick();
        checkOutput("rbw B", 32'(ReadDataB), 32'h0001);
        tick();
        readCheck("rbw after", 16'd7, 16'h0002);

        // Boundary addresses and out-of-range accesses.
        writeWord(16'd255, 16'hC0DE, 2'b11);
        checkOutput("addr255 Error", 32'(ErrorA), 32'd0);
        readCheck("addr255", 16'd255, 16'hC0DE);
        writeWord(16'd44, 16'h5555, 2'b11);
        writeWord(16'd0, 16'h6666, 2'b11);
        writeWord(16'd300, 16'hBEEF, 2'b11);
        checkOutput("oor wr Error A", 32'(ErrorA), 32'd1);
        checkOutput("oor wr Error B", 32'(ErrorB), 32'd1);
        tick();
        checkOutput("oor wr Error end", 32'(ErrorA), 32'd0);
        readCheck("no wrap 44", 16'd44, 16'h5555);
        writeWord(16'd256, 16'hDEAD, 2'b11);
        checkOutput("oor 256 Error", 32'(ErrorA), 32'd1);
        readCheck("no wrap 0", 16'd0, 16'h6666);
        readCheck("oor rd", 16'd300, 16'h0000);
        Adresa    = 16'd300;
        WriteData = 16'h1111;
        ByteEn    = 2'b11;
        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        tick();
        idleInputs();
        checkOutput("oor rw Error", 32'(ErrorA), 32'd1);
        tick();
        checkOutput("oor rw single pulse", 32'(ErrorA), 32'd0);
        tick();
        tick();

        // Reset with a dutB read in flight, requests ignored while clearing.
        Adresa  = 16'd13;
        MemRead = 1'b1;
        tick();
        idleInputs();
        Reset = 1'b1;
        tick();
        checkOutput("midrst B valid", 32'(ReadValidB), 32'd0);
        checkOutput("midrst B data",  32'(ReadDataB),  32'd0);
        checkOutput("midrst Ready",   32'(ReadyA),     32'd0);
        Reset = 1'b0;
        tick();
        tick();
        // Reset again partway through the clear: the count must restart.
        Reset = 1'b1;
        tick();
        Reset     = 1'b0;
        Adresa    = 16'd13;
        WriteData = 16'h1234;
        ByteEn    = 2'b11;
        MemWrite  = 1'b1;
        MemRead   = 1'b1;
        cnt       = 0;
        sawBad    = 1'b0;
        while (!ReadyA && cnt < 400) begin
            tick();
            cnt++;
            if (ReadValidA || ReadValidB || ErrorA || ErrorB) sawBad = 1'b1;
        end
        idleInputs();
        checkOutput("reclear edges", 32'(cnt), 32'd256);
        checkOutput("reclear ignored", 32'(sawBad), 32'd0);
        readCheck("reclear addr13", 16'd13, 16'h0000);
    endtask

    initial begin
        Reset = 1'b1;
        idleInputs();
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
